// File: rtl/mdl_dmaseq_pkg.sv
// Shared definitions for the DMA cycle sequencer: FSM states, rotator phase
// indices and the rotator idle value.
package mdl_dmaseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_BUS,
        ST_OWN,
        ST_PAUSE
    } state_t;

    localparam int PH_AS   = 2;
    localparam int PH_WAIT = 4;
    localparam int PH_END  = 7;

    localparam logic [7:0] ROT8_RST = 8'h01;

endpackage

// File: rtl/mdl_dmaseq_rot8.sv
// One-hot 8-phase bus timing rotator: advances on enable, freezes on hold,
// and is forced back to phase S0 by a synchronous load.
module mdl_dmaseq_rot8
    import mdl_dmaseq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hold,
    input  logic       load,
    output logic [7:0] rot
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot <= ROT8_RST;
        end else if (load) begin
            rot <= ROT8_RST;
        end else if (en && !hold) begin
            rot <= {rot[6:0], rot[7]};
        end
    end

endmodule

// File: rtl/mdl_dmaseq.sv
// DMA cycle sequencer: 68000 bus arbitration (BR/BG/BGACK), word counting,
// address generation and the one-hot bus phase rotator.
module mdl_dmaseq
    import mdl_dmaseq_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int ADDR_W    = 23,
    parameter int BURST_MAX = 16
) (
    input  logic              i_MCLK,
    input  logic              i_RST,
    input  logic              i_CLK4M_PCEN_n,
    input  logic              i_START,
    input  logic [CNT_W-1:0]  i_LEN,
    input  logic [ADDR_W-1:0] i_ADDR,
    input  logic              i_DIR,
    input  logic              i_DMA_RQ,
    input  logic              i_BG_n,
    input  logic              i_AS_n,
    input  logic              i_DTACK_n,
    output logic              o_BR_n,
    output logic              o_BGACK_n,
    output logic [7:0]        o_ROT8,
    output logic              o_DMA_ACT,
    output logic              o_DMA_WR_ACT_n,
    output logic [ADDR_W-1:0] o_ADDR,
    output logic              o_WORD_ACK,
    output logic              o_DONE,
    output logic              o_BUSY
);

    localparam int BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] burst_nxt;
    logic               dir;
    logic               tick;
    logic               rot_hold;
    logic               rot_load;
    logic               burst_hit;
    logic [7:0]         rot;

    assign tick      = ~i_CLK4M_PCEN_n;
    assign rot_load  = (state != ST_OWN);
    assign rot_hold  = rot[PH_WAIT] & i_DTACK_n;
    assign burst_nxt = burst + 1'b1;
    assign burst_hit = (BURST_MAX != 0) && (burst_nxt == BURST_LIM);

    assign o_ROT8         = rot;
    assign o_DMA_WR_ACT_n = ~(o_DMA_ACT & dir);

    mdl_dmaseq_rot8 u_rot8 (
        .clk  (i_MCLK),
        .rst  (i_RST),
        .en   (tick),
        .hold (rot_hold),
        .load (rot_load),
        .rot  (rot)
    );

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state      <= ST_IDLE;
            count      <= '0;
            burst      <= '0;
            dir        <= 1'b0;
            o_BR_n     <= 1'b1;
            o_BGACK_n  <= 1'b1;
            o_DMA_ACT  <= 1'b0;
            o_ADDR     <= '0;
            o_WORD_ACK <= 1'b0;
            o_DONE     <= 1'b0;
            o_BUSY     <= 1'b0;
        end else begin
            o_WORD_ACK <= 1'b0;
            o_DONE     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // BUSY while idle can only mean a zero-length transfer awaiting its DONE tick
                    if (o_BUSY) begin
                        if (tick) begin
                            o_DONE <= 1'b1;
                            o_BUSY <= 1'b0;
                        end
                    end else if (i_START) begin
                        o_ADDR <= i_ADDR;
                        count  <= i_LEN;
                        dir    <= i_DIR;
                        o_BUSY <= 1'b1;
                        if (i_LEN != '0) begin
                            state <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (tick && i_DMA_RQ) begin
                        state  <= ST_REQ;
                        o_BR_n <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (tick && !i_BG_n) begin
                        state <= ST_WAIT_BUS;
                    end
                end
                ST_WAIT_BUS: begin
                    if (tick && i_AS_n && i_DTACK_n && !i_BG_n) begin
                        state     <= ST_OWN;
                        o_BGACK_n <= 1'b0;
                        o_BR_n    <= 1'b1;
                        o_DMA_ACT <= 1'b1;
                        burst     <= '0;
                    end
                end
                ST_OWN: begin
                    // RQ is only consulted here, so a mid-cycle drop never cuts a cycle short
                    if (tick && rot[PH_END]) begin
                        o_WORD_ACK <= 1'b1;
                        o_ADDR     <= o_ADDR + 1'b1;
                        count      <= count - 1'b1;
                        burst      <= burst_nxt;
                        if (count == CNT_LAST) begin
                            o_DMA_ACT <= 1'b0;
                            o_BGACK_n <= 1'b1;
                            o_DONE    <= 1'b1;
                            o_BUSY    <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (burst_hit || !i_DMA_RQ) begin
                            o_DMA_ACT <= 1'b0;
                            o_BGACK_n <= 1'b1;
                            state     <= ST_PAUSE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdl_dmaseq.sv
// Bench for mdl_dmaseq: CPU bus-grant and DTACK responder plus per-scenario
// tasks comparing completed-word addresses against a scoreboard queue.
module tb_mdl_dmaseq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcen_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] len = '0;
    logic [22:0] addr = '0;
    logic        dir = 1'b0;
    logic        dma_rq = 1'b1;
    logic        bg_n = 1'b1;
    logic        as_n = 1'b1;
    logic        dtack_n = 1'b1;

    logic        br_n, bgack_n, dma_act, wr_act_n, word_ack, done, busy;
    logic [7:0]  rot8;
    logic [22:0] o_addr;

    mdl_dmaseq #(.CNT_W(12), .ADDR_W(23), .BURST_MAX(16)) dut (
        .i_MCLK         (clk),
        .i_RST          (rst),
        .i_CLK4M_PCEN_n (pcen_n),
        .i_START        (start),
        .i_LEN          (len),
        .i_ADDR         (addr),
        .i_DIR          (dir),
        .i_DMA_RQ       (dma_rq),
        .i_BG_n         (bg_n),
        .i_AS_n         (as_n),
        .i_DTACK_n      (dtack_n),
        .o_BR_n         (br_n),
        .o_BGACK_n      (bgack_n),
        .o_ROT8         (rot8),
        .o_DMA_ACT      (dma_act),
        .o_DMA_WR_ACT_n (wr_act_n),
        .o_ADDR         (o_addr),
        .o_WORD_ACK     (word_ack),
        .o_DONE         (done),
        .o_BUSY         (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int tick_no = 0;
    int ph = 0;
    int brcnt = 0;
    int wait_extra = 0;

    logic [22:0] exp_q[$];
    logic [22:0] obs_addr[$];
    int          ack_t[$];
    int          n_ack, n_done, n_brfall, n_rel, n_rot10, wr_bad, first_rel_ack;
    int          wait_arm, drop_arm;
    bit          saw_act;
    logic        cur_dir = 1'b0;

    always @(posedge clk) begin
        if (!pcen_n) tick_no <= tick_no + 1;
    end

    // CPU/bus responder: grant two ticks after BR, DTACK at S4 unless wait states are pending
    always @(negedge clk) begin
        if (rst || !bgack_n || br_n) begin
            bg_n  = 1'b1;
            brcnt = 0;
        end else if (!pcen_n) begin
            brcnt++;
            if (brcnt >= 2) bg_n = 1'b0;
        end
        ph     = (ph + 1) % 4;
        pcen_n = (ph != 0);
        if (!pcen_n && rot8 == 8'h10) begin
            if (wait_extra > 0) begin
                wait_extra--;
                dtack_n = 1'b1;
            end else begin
                dtack_n = 1'b0;
            end
        end else begin
            dtack_n = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_stats();
        exp_q.delete();
        obs_addr.delete();
        ack_t.delete();
        n_ack = 0; n_done = 0; n_brfall = 0; n_rel = 0; n_rot10 = 0; wr_bad = 0;
        first_rel_ack = -1; wait_arm = -1; drop_arm = -1; saw_act = 0;
    endtask

    task automatic start_xfer(input logic [11:0] l, input logic [22:0] a, input logic d, input bit push);
        logic [22:0] e;
        if (push) begin
            cur_dir = d;
            for (int k = 1; k <= int'(l); k++) begin
                e = a + 23'(k);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        len = l; addr = a; dir = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int budget, input int stop_acks, output bit timed_out);
        bit prev_br, prev_bgack, fin;
        prev_br = br_n;
        prev_bgack = bgack_n;
        fin = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            if (word_ack) begin
                n_ack++;
                ack_t.push_back(tick_no);
                obs_addr.push_back(o_addr);
            end
            if (done) n_done++;
            if (prev_br && !br_n) n_brfall++;
            if (!prev_bgack && bgack_n) begin
                n_rel++;
                if (first_rel_ack < 0) first_rel_ack = n_ack;
            end
            if (rot8 == 8'h10) n_rot10++;
            if (dma_act) begin
                saw_act = 1;
                if (wr_act_n !== ~cur_dir) wr_bad++;
            end
            if (wait_arm >= 0 && n_ack == wait_arm) begin
                wait_extra = 3;
                wait_arm = -1;
            end
            if (drop_arm >= 0 && n_ack == drop_arm && rot8 == 8'h08) begin
                dma_rq = 1'b0;
                drop_arm = -1;
            end
            prev_br = br_n;
            prev_bgack = bgack_n;
            if (done || (stop_acks > 0 && n_ack >= stop_acks)) fin = 1;
        end
        timed_out = !fin;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (br_n !== 1'b1)       begin fails++; $display("FAIL rst_br_n: got %b want 1", br_n); end
        tests++; if (bgack_n !== 1'b1)    begin fails++; $display("FAIL rst_bgack_n: got %b want 1", bgack_n); end
        tests++; if (rot8 !== 8'h01)      begin fails++; $display("FAIL rst_rot8: got %h want 01", rot8); end
        tests++; if (dma_act !== 1'b0)    begin fails++; $display("FAIL rst_dma_act: got %b want 0", dma_act); end
        tests++; if (wr_act_n !== 1'b1)   begin fails++; $display("FAIL rst_wr_act_n: got %b want 1", wr_act_n); end
        tests++; if (o_addr !== 23'h0)    begin fails++; $display("FAIL rst_addr: got %h want 0", o_addr); end
        tests++; if (word_ack !== 1'b0)   begin fails++; $display("FAIL rst_word_ack: got %b want 0", word_ack); end
        tests++; if (done !== 1'b0)       begin fails++; $display("FAIL rst_done: got %b want 0", done); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        bit to;
        logic [22:0] e, g;
        clear_stats();
        start_xfer(12'd3, 23'h000100, 1'b1, 1);
        run(1000, 0, to);
        tests++; if (to) begin fails++; $display("FAIL basic_done_timeout: got timeout want done"); end
        tests++; if (n_ack != 3)    begin fails++; $display("FAIL basic_nack: got %0d want 3", n_ack); end
        tests++; if (n_done != 1)   begin fails++; $display("FAIL basic_ndone: got %0d want 1", n_done); end
        tests++; if (n_brfall != 1) begin fails++; $display("FAIL basic_brfall: got %0d want 1", n_brfall); end
        tests++; if (!saw_act || wr_bad != 0) begin fails++; $display("FAIL basic_wr_act: act=%0d bad=%0d want act=1 bad=0", saw_act, wr_bad); end
        if (ack_t.size() >= 3) begin
            tests++; if (ack_t[1] - ack_t[0] != 8) begin fails++; $display("FAIL basic_space1: got %0d want 8", ack_t[1] - ack_t[0]); end
            tests++; if (ack_t[2] - ack_t[1] != 8) begin fails++; $display("FAIL basic_space2: got %0d want 8", ack_t[2] - ack_t[1]); end
        end
        while (exp_q.size() > 0 && obs_addr.size() > 0) begin
            e = exp_q.pop_front(); g = obs_addr.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL basic_addr: got %h want %h", g, e); end
        end
        tests++; if (busy !== 1'b0 || o_addr !== 23'h000103) begin fails++; $display("FAIL basic_end: busy=%b addr=%h want 0 000103", busy, o_addr); end
    endtask

    task automatic test_wait_state();
        bit to;
        logic [22:0] e, g;
        clear_stats();
        wait_arm = 1;
        start_xfer(12'd3, 23'h000020, 1'b0, 1);
        run(1000, 0, to);
        tests++; if (to || n_ack != 3) begin fails++; $display("FAIL wait_nack: got %0d (timeout %0d) want 3", n_ack, to); end
        if (ack_t.size() >= 3) begin
            tests++; if (ack_t[1] - ack_t[0] != 11) begin fails++; $display("FAIL wait_space_held: got %0d want 11", ack_t[1] - ack_t[0]); end
            tests++; if (ack_t[2] - ack_t[1] != 8)  begin fails++; $display("FAIL wait_space_next: got %0d want 8", ack_t[2] - ack_t[1]); end
        end
        tests++; if (n_rot10 != 24) begin fails++; $display("FAIL wait_s4_clocks: got %0d want 24", n_rot10); end
        tests++; if (wr_bad != 0) begin fails++; $display("FAIL wait_wr_act: got %0d bad want 0", wr_bad); end
        while (exp_q.size() > 0 && obs_addr.size() > 0) begin
            e = exp_q.pop_front(); g = obs_addr.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL wait_addr: got %h want %h", g, e); end
        end
    endtask

    task automatic test_burst();
        bit to;
        logic [22:0] e, g;
        clear_stats();
        start_xfer(12'd20, 23'h001000, 1'b1, 1);
        run(4000, 0, to);
        tests++; if (to || n_ack != 20) begin fails++; $display("FAIL burst_nack: got %0d (timeout %0d) want 20", n_ack, to); end
        tests++; if (first_rel_ack != 16) begin fails++; $display("FAIL burst_release_at: got %0d want 16", first_rel_ack); end
        tests++; if (n_brfall != 2) begin fails++; $display("FAIL burst_brfall: got %0d want 2", n_brfall); end
        tests++; if (n_done != 1)   begin fails++; $display("FAIL burst_ndone: got %0d want 1", n_done); end
        while (exp_q.size() > 0 && obs_addr.size() > 0) begin
            e = exp_q.pop_front(); g = obs_addr.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL burst_addr: got %h want %h", g, e); end
        end
    endtask

    task automatic test_len0_and_wrap();
        bit to;
        logic [22:0] e, g;
        clear_stats();
        start_xfer(12'd0, 23'h000055, 1'b0, 1);
        run(12, 0, to);
        tests++; if (to || n_done != 1) begin fails++; $display("FAIL len0_done: got %0d (timeout %0d) want 1", n_done, to); end
        tests++; if (n_brfall != 0 || br_n !== 1'b1) begin fails++; $display("FAIL len0_br: falls=%0d br_n=%b want 0 1", n_brfall, br_n); end
        tests++; if (n_ack != 0 || busy !== 1'b0) begin fails++; $display("FAIL len0_idle: acks=%0d busy=%b want 0 0", n_ack, busy); end
        clear_stats();
        start_xfer(12'd2, 23'h7FFFFF, 1'b0, 1);
        run(1000, 0, to);
        tests++; if (to || n_ack != 2) begin fails++; $display("FAIL wrap_nack: got %0d (timeout %0d) want 2", n_ack, to); end
        tests++; if (!saw_act || wr_bad != 0) begin fails++; $display("FAIL wrap_rd_act: act=%0d bad=%0d want 1 0", saw_act, wr_bad); end
        while (exp_q.size() > 0 && obs_addr.size() > 0) begin
            e = exp_q.pop_front(); g = obs_addr.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL wrap_addr: got %h want %h", g, e); end
        end
    endtask

    task automatic test_rq_drop();
        bit to;
        logic [22:0] e, g;
        clear_stats();
        drop_arm = 1;
        start_xfer(12'd5, 23'h000200, 1'b1, 1);
        run(1000, 2, to);
        tests++; if (to || n_rel != 1) begin fails++; $display("FAIL rqdrop_release: got %0d (timeout %0d) want 1", n_rel, to); end
        run(120, 0, to);
        tests++; if (n_ack != 2) begin fails++; $display("FAIL rqdrop_paused_acks: got %0d want 2", n_ack); end
        tests++; if (br_n !== 1'b1 || dma_act !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL rqdrop_pause_state: br_n=%b act=%b busy=%b want 1 0 1", br_n, dma_act, busy);
        end
        start_xfer(12'd1, 23'h000000, 1'b0, 0);
        dma_rq = 1'b1;
        run(1500, 0, to);
        tests++; if (to || n_ack != 5) begin fails++; $display("FAIL rqdrop_nack: got %0d (timeout %0d) want 5", n_ack, to); end
        tests++; if (n_brfall != 2 || n_done != 1) begin fails++; $display("FAIL rqdrop_tenures: falls=%0d done=%0d want 2 1", n_brfall, n_done); end
        tests++; if (o_addr !== 23'h000205 || wr_bad != 0) begin fails++; $display("FAIL rqdrop_end: addr=%h bad=%0d want 000205 0", o_addr, wr_bad); end
        while (exp_q.size() > 0 && obs_addr.size() > 0) begin
            e = exp_q.pop_front(); g = obs_addr.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL rqdrop_addr: got %h want %h", g, e); end
        end
    endtask

    task automatic test_reset_own();
        bit reached;
        int dn;
        clear_stats();
        wait_extra = 1000;
        start_xfer(12'd4, 23'h000040, 1'b1, 1);
        reached = 0;
        for (int c = 0; c < 600 && !reached; c++) begin
            @(negedge clk);
            if (rot8 == 8'h10 && dma_act) reached = 1;
        end
        tests++; if (!reached) begin fails++; $display("FAIL rstown_reach_s4: got no S4 hold want rot8=10 in OWN"); end
        #1 rst = 1'b1;
        @(negedge clk);
        tests++; if (bgack_n !== 1'b1 || br_n !== 1'b1) begin fails++; $display("FAIL rstown_bus: bgack_n=%b br_n=%b want 1 1", bgack_n, br_n); end
        tests++; if (dma_act !== 1'b0 || rot8 !== 8'h01) begin fails++; $display("FAIL rstown_act: act=%b rot8=%h want 0 01", dma_act, rot8); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstown_busy: got %b want 0", busy); end
        rst = 1'b0;
        wait_extra = 0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        tests++; if (dn != 0) begin fails++; $display("FAIL rstown_no_done: got %0d pulses want 0", dn); end
        exp_q.delete();
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_basic();
        test_wait_state();
        test_burst();
        test_len0_and_wrap();
        test_rq_drop();
        test_reset_own();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
